// File: rtl/crg_pkg.sv
// Shared types and helpers for the clock-gate enable sequencer.
package crg_pkg;

    typedef enum logic [1:0] {
        CG_OFF       = 2'd0,
        CG_WAKE      = 2'd1,
        CG_ON        = 2'd2,
        CG_IDLE_WAIT = 2'd3
    } cg_state_e;

    // One extra bit of headroom over the largest count ever loaded (max-1).
    function automatic int cg_cnt_w(input int wake, input int idle);
        int m;
        m = (wake > idle) ? wake : idle;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_chan.sv
// One clock-gate channel: wakes on want, reports settled clock, gates after idle hysteresis.
module clk_gate_ctrl_chan
    import crg_pkg::*;
#(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      want,
    input  logic      idle,
    output logic      en,
    output logic      ack,
    output cg_state_e state
);

    localparam int CW = cg_cnt_w(WAKE_CYCLES, IDLE_CYCLES);
    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Valid/ready does not apply here: want/idle are levels sampled every edge,
    // and ack is the level "clock running and settled" back to the domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CG_OFF;
            en    <= 1'b0;
            ack   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                CG_OFF: begin
                    if (want) begin
                        state <= CG_WAKE;
                        en    <= 1'b1;
                        cnt   <= WAKE_LOAD;
                    end
                end
                CG_WAKE: begin
                    // A dropped request does not abort the wake; the gate settles first.
                    if (cnt == '0) begin
                        state <= CG_ON;
                        ack   <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CG_ON: begin
                    if (!want && idle) begin
                        state <= CG_IDLE_WAIT;
                        cnt   <= IDLE_LOAD;
                    end
                end
                CG_IDLE_WAIT: begin
                    // Abort beats terminal count so a late request never loses the clock.
                    if (want || !idle) begin
                        state <= CG_ON;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state <= CG_OFF;
                        en    <= 1'b0;
                        ack   <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= CG_OFF;
                    en    <= 1'b0;
                    ack   <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Per-domain clock-enable sequencer: NUM_DOMAINS independent gate channels plus ALL_OFF.
module clk_gate_ctrl
    import crg_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     FORCE_ON,
    input  logic [NUM_DOMAINS-1:0]   REQ,
    input  logic [NUM_DOMAINS-1:0]   IDLE,
    output logic [NUM_DOMAINS-1:0]   EN,
    output logic [NUM_DOMAINS-1:0]   ACK,
    output logic                     ALL_OFF,
    output logic [2*NUM_DOMAINS-1:0] DBG_STATE
);

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_chan
        cg_state_e chan_state;

        clk_gate_ctrl_chan #(
            .WAKE_CYCLES(WAKE_CYCLES),
            .IDLE_CYCLES(IDLE_CYCLES)
        ) u_chan (
            .clk  (CLK),
            .rst_n(RST_N),
            .want (REQ[i] | FORCE_ON),
            .idle (IDLE[i]),
            .en   (EN[i]),
            .ack  (ACK[i]),
            .state(chan_state)
        );

        assign DBG_STATE[2*i +: 2] = chan_state;
    end

    assign ALL_OFF = ~|EN;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed and randomized checks of clk_gate_ctrl against a cycle-count reference model.
module tb_clk_gate_ctrl;

    localparam int N  = 4;
    localparam int WK = 2;
    localparam int IC = 16;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic           FORCE_ON;
    logic [N-1:0]   REQ;
    logic [N-1:0]   IDLE;
    logic [N-1:0]   EN;
    logic [N-1:0]   ACK;
    logic           ALL_OFF;
    logic [2*N-1:0] DBG_STATE;

    int checks   = 0;
    int failures = 0;

    // Reference model: EN rises on a wanted edge, ACK follows WK edges later,
    // and an acked domain drops after IC+1 consecutive edges of (!want & idle).
    bit m_en[N];
    bit m_ack[N];
    int since[N];
    int streak[N];

    clk_gate_ctrl #(
        .NUM_DOMAINS(N),
        .WAKE_CYCLES(WK),
        .IDLE_CYCLES(IC)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .FORCE_ON (FORCE_ON),
        .REQ      (REQ),
        .IDLE     (IDLE),
        .EN       (EN),
        .ACK      (ACK),
        .ALL_OFF  (ALL_OFF),
        .DBG_STATE(DBG_STATE)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_en[i]   = 1'b0;
            m_ack[i]  = 1'b0;
            since[i]  = 0;
            streak[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit want;
        if (!RST_N) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) begin
            want = REQ[i] | FORCE_ON;
            if (!m_en[i]) begin
                if (want) begin
                    m_en[i]  = 1'b1;
                    since[i] = 0;
                end
            end else if (!m_ack[i]) begin
                since[i]++;
                if (since[i] == WK) begin
                    m_ack[i]  = 1'b1;
                    streak[i] = 0;
                end
            end else begin
                if (!want && IDLE[i]) streak[i]++;
                else streak[i] = 0;
                if (streak[i] == IC + 1) begin
                    m_en[i]   = 1'b0;
                    m_ack[i]  = 1'b0;
                    streak[i] = 0;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] exp_en;
        logic [N-1:0] exp_ack;
        for (int i = 0; i < N; i++) begin
            exp_en[i]  = m_en[i];
            exp_ack[i] = m_ack[i];
        end
        checks++;
        assert (EN === exp_en) else begin
            failures++;
            $error("FAIL %s.en got=%b exp=%b", tag, EN, exp_en);
        end
        checks++;
        assert (ACK === exp_ack) else begin
            failures++;
            $error("FAIL %s.ack got=%b exp=%b", tag, ACK, exp_ack);
        end
        checks++;
        assert (ALL_OFF === (exp_en == '0)) else begin
            failures++;
            $error("FAIL %s.all_off got=%b exp=%b", tag, ALL_OFF, (exp_en == '0));
        end
    endtask

    task automatic expect_vec(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic expect_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    initial begin
        RST_N    = 1'b0;
        FORCE_ON = 1'b0;
        REQ      = '0;
        IDLE     = '0;
        model_reset();

        // Reset held for five edges
        ticks(5, "reset");
        expect_vec("reset_en", EN, 4'b0000);
        expect_vec("reset_ack", ACK, 4'b0000);
        expect_bit("reset_all_off", ALL_OFF, 1'b1);
        RST_N = 1'b1;
        ticks(2, "post_reset");

        // Wake on request
        REQ = 4'b0001;
        tick("wake");
        expect_vec("wake_en", EN, 4'b0001);
        expect_vec("wake_ack_early", ACK, 4'b0000);
        expect_bit("wake_all_off", ALL_OFF, 1'b0);
        tick("wake");
        expect_vec("wake_ack_mid", ACK, 4'b0000);
        tick("wake");
        expect_vec("wake_ack", ACK, 4'b0001);
        ticks(3, "on");

        // Idle gating: EN holds IC edges, falls on the next
        REQ  = 4'b0000;
        IDLE = 4'b0001;
        ticks(IC, "idle_hold");
        expect_vec("idle_hold_en", EN, 4'b0001);
        expect_vec("idle_hold_ack", ACK, 4'b0001);
        tick("idle_gate");
        expect_vec("idle_gate_en", EN, 4'b0000);
        expect_vec("idle_gate_ack", ACK, 4'b0000);
        expect_bit("idle_gate_all_off", ALL_OFF, 1'b1);

        // Idle abort restarts the full count
        REQ  = 4'b0001;
        IDLE = 4'b0000;
        ticks(5, "rewake");
        REQ  = 4'b0000;
        IDLE = 4'b0001;
        ticks(8, "idle_partial");
        IDLE = 4'b0000;
        ticks(2, "idle_abort");
        IDLE = 4'b0001;
        ticks(IC, "idle_restart");
        expect_vec("restart_hold_en", EN, 4'b0001);
        tick("idle_restart_gate");
        expect_vec("restart_gate_en", EN, 4'b0000);

        // Request arrives on the terminal-count edge
        REQ  = 4'b0001;
        IDLE = 4'b0000;
        ticks(5, "rewake2");
        REQ  = 4'b0000;
        IDLE = 4'b0001;
        ticks(IC, "collide_hold");
        REQ = 4'b0001;
        tick("collide");
        expect_vec("collide_en", EN, 4'b0001);
        expect_vec("collide_ack", ACK, 4'b0001);
        ticks(20, "collide_after");
        expect_vec("collide_after_en", EN, 4'b0001);

        // Return to all-off, then FORCE_ON
        REQ  = 4'b0000;
        IDLE = 4'b1111;
        ticks(IC + 2, "drain");
        expect_vec("drain_en", EN, 4'b0000);
        FORCE_ON = 1'b1;
        tick("force");
        expect_vec("force_en", EN, 4'b1111);
        expect_vec("force_ack_early", ACK, 4'b0000);
        ticks(2, "force_wake");
        expect_vec("force_ack", ACK, 4'b1111);
        ticks(30, "force_hold");
        expect_vec("force_hold_en", EN, 4'b1111);
        FORCE_ON = 1'b0;
        ticks(IC, "force_release");
        expect_vec("release_hold_en", EN, 4'b1111);
        tick("force_gate");
        expect_vec("release_gate_en", EN, 4'b0000);

        // Asynchronous reset in the middle of a wake
        IDLE = 4'b0000;
        REQ  = 4'b0100;
        tick("pre_async");
        expect_vec("pre_async_en", EN, 4'b0100);
        expect_vec("pre_async_ack", ACK, 4'b0000);
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        expect_vec("async_en", EN, 4'b0000);
        expect_vec("async_ack", ACK, 4'b0000);
        expect_bit("async_all_off", ALL_OFF, 1'b1);
        #2;
        RST_N = 1'b1;
        tick("async_rewake");
        expect_vec("async_rewake_en", EN, 4'b0100);
        ticks(2, "async_rewake");
        expect_vec("async_rewake_ack", ACK, 4'b0100);

        // Randomized segments of held inputs
        for (int s = 0; s < 80; s++) begin
            REQ      = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            IDLE     = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            FORCE_ON = ($urandom_range(0, 9) == 0);
            ticks($urandom_range(1, 24), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
